// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: bus widths, reset level, entry layout and FSM encodings.
// Imported by inst_fetch and inst_fetch_fifo.
package inst_fetch_pkg;

    localparam int           INST_ADDR_W      = 32;
    localparam int           INST_W           = 32;
    localparam logic [31:0]  ZERO_WORD        = 32'h0000_0000;
    localparam logic         RSTN_ENABLE      = 1'b0;
    localparam int           INST_WIDTH_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch buffer of {pc, inst} entries with push/pop/clear.
// Latency: pushed entry visible at head the cycle after the push edge.
// Backpressure: none internal; the caller reserves space before pushing.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  fetch_entry_t          push_dat,
    input  logic                  pop,
    input  logic                  clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                  empty,
    output fetch_entry_t          head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign empty = (count == '0);
    // Empty head reads as pc 0 / NOP so decode never sees stale storage.
    assign head  = empty ? {ZERO_WORD, ZERO_WORD} : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC + req/ack memory FSM feeding a prefetch FIFO for decode.
// Latency: word acked at edge N appears on pc_o/inst_o after edge N; one word/cycle sustained.
// Backpressure: stall_i holds the head; requests issue only with a reserved FIFO slot.
// Optional INST_FETCH_PERF_EN adds fetch_cnt_o / bubble_cnt_o counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_inc;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t     push_dat;
    fetch_entry_t     head;

    assign pop          = inst_valid_o && !stall_i && !flush_i;
    assign push         = (state == FETCH_WAIT) && rom_ack_i && !flush_i;
    // Occupancy after this edge's push and any same-edge pop.
    assign count_after  = count + CNT_W'(1) - CNT_W'(pop);
    assign fetch_pc_inc = fetch_pc + 32'(INST_WIDTH_BYTES);
    assign push_dat     = '{pc: rom_addr_o, inst: rom_data_i};

    inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .clear    (flush_i),
        .count    (count),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign inst_valid_o = !fifo_empty;
    assign pc_o         = head.pc;
    assign inst_o       = head.inst;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            state      <= FETCH_IDLE;
            fetch_pc   <= RESET_PC;
            rom_req_o  <= 1'b0;
            rom_addr_o <= ZERO_WORD;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (flush_i) begin
                        fetch_pc <= align_pc(new_pc_i);
                    end else if (count < DEPTH_C) begin
                        state      <= FETCH_WAIT;
                        rom_req_o  <= 1'b1;
                        rom_addr_o <= fetch_pc;
                    end
                end
                FETCH_WAIT: begin
                    if (flush_i) begin
                        fetch_pc <= align_pc(new_pc_i);
                        if (rom_ack_i) begin
                            state     <= FETCH_IDLE;
                            rom_req_o <= 1'b0;
                        end else begin
                            // Memory still owes this word; keep the handshake and drop it later.
                            state <= FETCH_DISCARD;
                        end
                    end else if (rom_ack_i) begin
                        fetch_pc <= fetch_pc_inc;
                        if (count_after < DEPTH_C) begin
                            rom_addr_o <= fetch_pc_inc;
                        end else begin
                            state     <= FETCH_IDLE;
                            rom_req_o <= 1'b0;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (flush_i) begin
                        fetch_pc <= align_pc(new_pc_i);
                    end
                    if (rom_ack_i) begin
                        state     <= FETCH_IDLE;
                        rom_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= FETCH_IDLE;
                    rom_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (pop) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (!inst_valid_o && !stall_i) bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a pc-stream scoreboard and memory model.
module tb_inst_fetch;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_ack_i = 1'b0;
    logic [31:0] rom_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_bubble = '0;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_ack_i    (rom_ack_i),
        .rom_data_i   (rom_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
`ifdef INST_FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic [31:0] exp_pc = 32'h0000_0000;
    logic [31:0] prev_addr = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mid-cycle: check handshake invariants, then drive memory for the coming edge.
    task automatic begin_cycle();
        @(negedge clk);
        if (prev_req && !prev_ack) begin
            chk("req_hold", 32'(rom_req_o), 32'd1);
            chk("addr_hold", rom_addr_o, prev_addr);
        end
        if (!inst_valid_o) chk("nop_when_empty", inst_o, 32'h0);
        if (rom_ack_i) wait_cnt = 0;
        if (rom_req_o) begin
            wait_cnt++;
            rom_ack_i = (lat == 0) ? 1'($urandom_range(0, 1)) : (wait_cnt >= lat);
        end else begin
            wait_cnt  = 0;
            rom_ack_i = 1'b0;
        end
        rom_data_i = rom_ack_i ? (rom_addr_o ^ MAGIC) : $urandom;
    endtask

    // Apply decode-side inputs and score what the coming edge consumes.
    task automatic end_cycle(input logic st, input logic fl, input logic [31:0] npc);
        stall_i  = st;
        flush_i  = fl;
        new_pc_i = npc;
`ifdef INST_FETCH_PERF_EN
        if (!inst_valid_o && !st) exp_bubble++;
        if (inst_valid_o && !st && !fl) exp_fetch++;
`endif
        if (fl) begin
            exp_pc = {npc[31:2], 2'b00};
        end else if (inst_valid_o && !st) begin
            chk("pop_pc", pc_o, exp_pc);
            chk("pop_inst", inst_o, exp_pc ^ MAGIC);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        prev_req  = rom_req_o;
        prev_ack  = rom_ack_i;
        prev_addr = rom_addr_o;
    endtask

    task automatic cyc(input logic st, input logic fl, input logic [31:0] npc);
        begin_cycle();
        end_cycle(st, fl, npc);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          p0;
        bit          hit;
        logic [31:0] held;
        logic        st;
        logic        fl;

        #12;
        chk("rst_req", 32'(rom_req_o), 32'd0);
        chk("rst_addr", rom_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        end_cycle(1'b0, 1'b0, 32'h0);

        // Streaming with single-cycle ack.
        lat = 1;
        for (int i = 0; i < 30; i++) begin
            begin_cycle();
            if (i >= 2) chk("stream_valid", 32'(inst_valid_o), 32'd1);
            end_cycle(1'b0, 1'b0, 32'h0);
        end

        // Long stall: FIFO fills, request stops, head frozen.
        held = 32'h0;
        for (int i = 0; i < 10; i++) begin
            begin_cycle();
            if (i == 0) held = pc_o;
            if (i == 9) begin
                chk("stall_pc", pc_o, held);
                chk("stall_req", 32'(rom_req_o), 32'd0);
                chk("stall_valid", 32'(inst_valid_o), 32'd1);
            end
            end_cycle(1'b1, 1'b0, 32'h0);
        end

        // Three-cycle memory latency.
        lat = 3;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0);
        p0 = pops;
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("lat3_rate", 32'((pops - p0) >= 9 && (pops - p0) <= 11), 32'd1);

        // Flush while a request is pending: old word discarded, redirect to 0x1000.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            begin_cycle();
            if (rom_req_o && !rom_ack_i) begin
                end_cycle(1'b0, 1'b1, 32'h0000_1003);
                hit = 1'b1;
            end else begin
                end_cycle(1'b0, 1'b0, 32'h0);
            end
        end
        chk("flush4_hit", 32'(hit), 32'd1);
        begin_cycle();
        chk("flush4_empty", 32'(inst_valid_o), 32'd0);
        chk("flush4_discard_req", 32'(rom_req_o), 32'd1);
        end_cycle(1'b0, 1'b0, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            begin_cycle();
            if (rom_req_o && !prev_req) begin
                chk("redirect_addr", rom_addr_o, 32'h0000_1000);
                hit = 1'b1;
            end
            end_cycle(1'b0, 1'b0, 32'h0);
        end
        chk("redirect_seen", 32'(hit), 32'd1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0);

        // Flush coinciding with ack under stall.
        lat = 1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            begin_cycle();
            if (rom_ack_i) begin
                end_cycle(1'b1, 1'b1, 32'h0000_2000);
                hit = 1'b1;
            end else begin
                end_cycle(1'b0, 1'b0, 32'h0);
            end
        end
        chk("flush5_hit", 32'(hit), 32'd1);
        begin_cycle();
        chk("flush5_empty", 32'(inst_valid_o), 32'd0);
        end_cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
        begin_cycle();
        chk("flush5_head", pc_o, 32'h0000_2000);
        end_cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
        p0 = pops;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_progress", 32'((pops - p0) >= 5), 32'd1);

        // Random stall, flush and memory latency.
        lat = 0;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            begin_cycle();
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 49) == 0);
            end_cycle(st, fl, $urandom);
        end
        chk("random_progress", 32'((pops - p0) > 300), 32'd1);

        begin_cycle();
`ifdef INST_FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt_o, exp_fetch);
        chk("bubble_cnt", bubble_cnt_o, exp_bubble);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
